// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared constants, types and small helpers for the MEM pipeline stage.
//   - WB_MEM       : write-back source selector value meaning "from memory".
//   - FLAG_ZERO    : bit index of the ZERO flag in the flag register.
//   - NUM_FLAGS    : number of architectural flags (flag_sel >= NUM_FLAGS reads 0).
//   - mem_state_t  : data-memory access FSM states.
//   - is_load_op   : decodes a load from the EX/MEM control fields.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam int         FLAG_ZERO  = 0;
  localparam int         NUM_FLAGS  = 6;
  localparam int         FLAG_SEL_W = 3;

  typedef enum logic [0:0] {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_t;

  // A store takes priority when both store and memory write-back are flagged.
  function automatic logic is_load_op(input logic       in_valid,
                                      input logic       mem_write_enable,
                                      input logic [1:0] wb_res_mux);
    return in_valid & ~mem_write_enable & (wb_res_mux == WB_MEM);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Data-memory request/acknowledge bus between the MEM stage and memory.
//   req   : request held high until ack or timeout
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write data
//   rdata : read data, valid together with ack
//   ack   : one-cycle completion pulse from memory
//   Modports: master (pipeline stage side), slave (memory side).
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_branch_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_branch_unit
//   Combinational branch resolution for PC-relative branches.
//   Inputs : in_valid, is_branch, sel_jflag_branch (0=beq/bne, 1=jt/jf),
//            sel_beq_bne (0=beq, 1=bne), sel_jt_jf (0=jt, 1=jf),
//            flag_sel (flag index for jt/jf), flags (bit0 = ZERO)
//   Output : taken (branch condition satisfied for a real branch)
// -----------------------------------------------------------------------------
module mem_stage_branch_unit
  import mem_stage_pkg::*;
(
  input  logic                  in_valid,
  input  logic                  is_branch,
  input  logic                  sel_jflag_branch,
  input  logic                  sel_beq_bne,
  input  logic                  sel_jt_jf,
  input  logic [FLAG_SEL_W-1:0] flag_sel,
  input  logic [NUM_FLAGS-1:0]  flags,
  output logic                  taken
);

  localparam int SEL_SPAN = 1 << FLAG_SEL_W;

  // Flag vector widened to every flag_sel code; codes past the last real
  // flag read as constant 0 so jt never fires and jf always fires on them.
  logic [SEL_SPAN-1:0] flag_ext;

  genvar gi;
  generate
    for (gi = 0; gi < SEL_SPAN; gi++) begin : g_flag_ext
      if (gi < NUM_FLAGS) begin : g_real
        assign flag_ext[gi] = flags[gi];
      end else begin : g_zero
        assign flag_ext[gi] = 1'b0;
      end
    end
  endgenerate

  logic flag_bit;
  logic cond;

  assign flag_bit = flag_ext[flag_sel];

  // The select bits invert the sense of the tested flag.
  assign cond  = sel_jflag_branch ? (flag_bit ^ sel_jt_jf)
                                  : (flags[FLAG_ZERO] ^ sel_beq_bne);
  assign taken = in_valid & is_branch & cond;

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MEM pipeline stage of core_lapido. Performs data-memory loads/stores over
//   a req/ack bus, stalls the front of the pipeline while memory is busy,
//   resolves PC-relative branches and registers the MEM/WB fields.
//   Ports:
//     clk, rst                 clock; asynchronous active-high reset
//     EX/MEM fields            in_valid, control bits, alu_res, mem_data,
//                              flags, branch_addr, next_pc, imm, reg_dest
//     dmem (master modport)    data-memory request bus
//     stall                    hold IF..EX/MEM this cycle
//     branch_taken/_target     registered one-cycle PC redirect
//     bus_error                sticky memory timeout indicator
//     out_*                    MEM/WB pipeline register
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int RADDR_W  = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  in_valid,
  input  logic                  mem_write_enable,
  input  logic                  sel_beq_bne,
  input  logic                  sel_jt_jf,
  input  logic                  is_branch,
  input  logic                  sel_jflag_branch,
  input  logic [FLAG_SEL_W-1:0] flag_sel,
  input  logic [1:0]            wb_res_mux,
  input  logic                  reg_write_enable,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [NUM_FLAGS-1:0]  flags,
  input  logic [PC_W-1:0]       branch_addr,
  input  logic [PC_W-1:0]       next_pc,
  input  logic [DATA_W-1:0]     imm,
  input  logic [RADDR_W-1:0]    reg_dest,

  mem_stage_if.master           dmem,

  output logic                  stall,
  output logic                  branch_taken,
  output logic [PC_W-1:0]       branch_target,
  output logic                  bus_error,

  output logic [1:0]            out_wb_res_mux,
  output logic                  out_reg_write_enable,
  output logic [RADDR_W-1:0]    out_reg_dest,
  output logic [DATA_W-1:0]     out_alu_res,
  output logic [DATA_W-1:0]     out_mem_data,
  output logic [PC_W-1:0]       out_next_pc,
  output logic [DATA_W-1:0]     out_imm
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic is_store;
  logic is_load;
  logic mem_op;

  assign is_store = in_valid & mem_write_enable;
  assign is_load  = is_load_op(in_valid, mem_write_enable, wb_res_mux);
  assign mem_op   = is_store | is_load;

  // ---------------------------------------------------------------------------
  // Branch resolution
  // ---------------------------------------------------------------------------
  logic br_taken;

  mem_stage_branch_unit u_branch_unit (
    .in_valid         (in_valid),
    .is_branch        (is_branch),
    .sel_jflag_branch (sel_jflag_branch),
    .sel_beq_bne      (sel_beq_bne),
    .sel_jt_jf        (sel_jt_jf),
    .flag_sel         (flag_sel),
    .flags            (flags),
    .taken            (br_taken)
  );

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  mem_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  // Request captured on entry so the bus stays stable for the whole access
  // even if the upstream hold were imperfect.
  logic              acc_we_reg;
  logic [DATA_W-1:0] acc_addr_reg;
  logic [DATA_W-1:0] acc_wdata_reg;

  logic              req_c;
  logic              we_c;
  logic [DATA_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              stall_c;
  logic              complete_c;   // ack accepted this cycle
  logic              timeout_c;    // wait budget exhausted this cycle
  logic              capture_c;    // latch request, entering ACCESS

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    stall_c    = 1'b0;
    complete_c = 1'b0;
    timeout_c  = 1'b0;
    capture_c  = 1'b0;

    unique case (state_reg)
      MEM_IDLE: begin
        // An ack arriving without a fresh request here is stale and ignored.
        if (mem_op) begin
          req_c   = 1'b1;
          we_c    = is_store;
          addr_c  = alu_res;
          wdata_c = mem_data;
          if (dmem.ack) begin
            complete_c = 1'b1;
          end else begin
            stall_c    = 1'b1;
            capture_c  = 1'b1;
            count_next = '0;
            state_next = MEM_ACCESS;
          end
        end
      end

      MEM_ACCESS: begin
        req_c   = 1'b1;
        we_c    = acc_we_reg;
        addr_c  = acc_addr_reg;
        wdata_c = acc_wdata_reg;
        // An ack on the last allowed cycle still wins over the timeout.
        if (dmem.ack) begin
          complete_c = 1'b1;
          count_next = '0;
          state_next = MEM_IDLE;
        end else if (count_reg == CNT_W'(MAX_WAIT - 1)) begin
          timeout_c  = 1'b1;
          count_next = '0;
          state_next = MEM_IDLE;
        end else begin
          stall_c    = 1'b1;
          count_next = count_reg + 1'b1;
        end
      end

      default: begin
        state_next = MEM_IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= MEM_IDLE;
      count_reg     <= '0;
      acc_we_reg    <= 1'b0;
      acc_addr_reg  <= '0;
      acc_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (capture_c) begin
        acc_we_reg    <= is_store;
        acc_addr_reg  <= alu_res;
        acc_wdata_reg <= mem_data;
      end
    end
  end

  // Bus and stall are combinational; gating with rst makes the request
  // vanish the instant reset asserts rather than at the next edge.
  assign dmem.req   = req_c & ~rst;
  assign dmem.we    = we_c & ~rst;
  assign dmem.addr  = rst ? '0 : addr_c;
  assign dmem.wdata = rst ? '0 : wdata_c;
  assign stall      = stall_c & ~rst;

  // ---------------------------------------------------------------------------
  // Sticky bus error, branch redirect
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_error     <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      if (timeout_c) begin
        bus_error <= 1'b1;
      end
      // A stalled instruction is presented again next cycle; only the cycle
      // it actually leaves the stage may redirect, so the pulse is single.
      branch_taken  <= br_taken & ~stall_c;
      branch_target <= branch_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wb_res_mux       <= '0;
      out_reg_write_enable <= 1'b0;
      out_reg_dest         <= '0;
      out_alu_res          <= '0;
      out_mem_data         <= '0;
      out_next_pc          <= '0;
      out_imm              <= '0;
    end else begin
      out_wb_res_mux <= wb_res_mux;
      out_reg_dest   <= reg_dest;
      out_alu_res    <= alu_res;
      out_next_pc    <= next_pc;
      out_imm        <= imm;
      // Bubble while stalled; a timed-out access retires without writing.
      out_reg_write_enable <= in_valid & reg_write_enable & ~stall_c & ~timeout_c;
      out_mem_data         <= (complete_c & ~we_c) ? dmem.rdata : '0;
    end
  end

endmodule
